// File: rtl/reciprocal_nr_if.sv
// Valid/ready channels of the Newton-Raphson reciprocal: operand in, result out.
interface reciprocal_nr_if #(
    parameter int W = 24
);
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_data;
    logic         i_abs;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_data;
    logic         o_sat;

    modport master (
        output i_valid, i_data, i_abs, i_ready,
        input  o_ready, o_valid, o_data, o_sat
    );

    modport slave (
        input  i_valid, i_data, i_abs, i_ready,
        output o_ready, o_valid, o_data, o_sat
    );
endinterface

// File: rtl/reciprocal_nr.sv
// Sequential Newton-Raphson reciprocal of a signed SQM.N operand using one
// shared multiplier on an unsigned Q2.F working format (F = M + N).
module reciprocal_nr #(
    parameter int M     = 12,
    parameter int N     = 12,
    parameter int ITERS = 3
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    reciprocal_nr_if.slave bus
);
    localparam int F  = M + N;
    localparam int W  = F + 2;
    localparam int LW = $clog2(F + 1);
    localparam int IW = $clog2(ITERS + 1);
    localparam int RW = (F + 3 > 2 * M + 2) ? F + 3 : 2 * M + 2;

    // Seed constant 2.9142 in Q2.F, rounded to nearest.
    localparam logic [63:0]  K_FULL = ((64'd29142 << F) + 64'd5000) / 64'd10000;
    localparam logic [W-1:0] K_SEED = K_FULL[W-1:0];
    localparam logic [W-1:0] TWO    = {2'b10, {F{1'b0}}};
    localparam logic [F-1:0] MAXP   = {1'b0, {(F - 1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE, S_NORM, S_SEED, S_MUL_T, S_MUL_X, S_SCALE, S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic           sign_q, sign_d, abs_q, abs_d, zero_q, zero_d, sat_q, sat_d;
    logic [F-1:0]   mag_q, mag_d, data_q, data_d;
    logic [LW-1:0]  lzc_q, lzc_d, lz;
    logic [W-1:0]   a_q, a_d, x_q, x_d, t_q, t_d;
    logic [IW-1:0]  iter_q, iter_d;
    logic [W-1:0]   op_a, op_b, prod_hi;
    logic [2*W-1:0] prod;
    logic           prod_unused;
    logic [RW-1:0]  raw;
    logic           sat_c;
    logic [F-1:0]   mag_out;
    int             shift;

    function automatic logic [LW-1:0] count_lz(input logic [F-1:0] v);
        logic [LW-1:0] n;
        n = LW'(F);
        for (int i = 0; i < F; i++) begin
            if (v[i]) n = LW'(F - 1 - i);
        end
        return n;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.i_valid) state_d = S_NORM;
            S_NORM:  state_d = S_SEED;
            S_SEED:  state_d = S_MUL_T;
            S_MUL_T: state_d = S_MUL_X;
            S_MUL_X: state_d = (iter_q == IW'(ITERS - 1)) ? S_SCALE : S_MUL_T;
            S_SCALE: state_d = S_DONE;
            S_DONE:  if (bus.i_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.o_ready = (state_q == S_IDLE);
        bus.o_valid = (state_q == S_DONE);
        bus.o_data  = data_q;
        bus.o_sat   = sat_q;
    end

    // The single multiplier: t = a*x in MUL_T, x = x*(2-t) in MUL_X.
    always_comb begin
        op_a = a_q;
        op_b = x_q;
        if (state_q == S_MUL_X) begin
            op_a = x_q;
            op_b = TWO - t_q;
        end
    end

    assign prod        = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
    assign prod_hi     = prod[2*F+1:F];
    assign prod_unused = ^{prod[2*W-1:2*F+2], prod[F-1:0]};

    always_comb begin
        sign_d  = sign_q;
        abs_d   = abs_q;
        mag_d   = mag_q;
        zero_d  = zero_q;
        lzc_d   = lzc_q;
        a_d     = a_q;
        x_d     = x_q;
        t_d     = t_q;
        iter_d  = iter_q;
        data_d  = data_q;
        sat_d   = sat_q;
        lz      = count_lz(mag_q);
        raw     = '0;
        sat_c   = 1'b0;
        mag_out = '0;
        shift   = 2 * M - int'(lzc_q);
        case (state_q)
            S_IDLE: if (bus.i_valid) begin
                sign_d = bus.i_data[F-1];
                abs_d  = bus.i_abs;
                mag_d  = bus.i_data[F-1] ? -bus.i_data : bus.i_data;
            end
            S_NORM: begin
                zero_d = (mag_q == '0);
                lzc_d  = lz;
                a_d    = {2'b00, mag_q << lz};
            end
            S_SEED: begin
                x_d    = K_SEED - {a_q[W-2:0], 1'b0};
                iter_d = '0;
            end
            S_MUL_T: t_d = prod_hi;
            S_MUL_X: begin
                x_d    = prod_hi;
                iter_d = iter_q + 1'b1;
            end
            S_SCALE: begin
                // A non-positive shift means the result is at least 2^F: saturate.
                if (shift >= 1) raw = (RW'(x_q) + (RW'(1) << (shift - 1))) >> shift;
                else            raw = '1;
                sat_c   = zero_q || (raw > RW'(MAXP));
                mag_out = sat_c ? MAXP : raw[F-1:0];
                data_d  = (sign_q && !abs_q && !zero_q) ? -mag_out : mag_out;
                sat_d   = sat_c;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sign_q <= 1'b0;
            abs_q  <= 1'b0;
            mag_q  <= '0;
            zero_q <= 1'b0;
            lzc_q  <= '0;
            a_q    <= '0;
            x_q    <= '0;
            t_q    <= '0;
            iter_q <= '0;
            data_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            sign_q <= sign_d;
            abs_q  <= abs_d;
            mag_q  <= mag_d;
            zero_q <= zero_d;
            lzc_q  <= lzc_d;
            a_q    <= a_d;
            x_q    <= x_d;
            t_q    <= t_d;
            iter_q <= iter_d;
            data_q <= data_d;
            sat_q  <= sat_d;
        end
    end
endmodule

// File: tb/tb_reciprocal_nr.sv
// Scoreboard bench for reciprocal_nr: a rational-arithmetic model queues the
// expected results and a negedge monitor compares every result transfer.
module tb_reciprocal_nr;
    localparam int M     = 12;
    localparam int N     = 12;
    localparam int ITERS = 3;
    localparam int F     = M + N;
    localparam longint MAXV = (longint'(1) << (F - 1)) - 1;

    typedef struct {
        bit           sat;
        longint       val;
        logic [F-1:0] opnd;
        bit           ab;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    bit     rand_ready = 1'b0;
    int     n_cmp = 0;
    int     n_bad = 0;
    int     n_xfer = 0;
    exp_t   exp_q[$];

    reciprocal_nr_if #(.W(F)) bus ();

    reciprocal_nr #(.M(M), .N(N), .ITERS(ITERS)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input bit ok, input longint got, input longint exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // Reference: nearest-integer 2^(2N)/|x|, clamped to the largest positive code.
    function automatic exp_t model(input logic [F-1:0] d, input bit ab);
        exp_t   e;
        longint m, q;
        bit     neg;
        neg    = d[F-1];
        m      = neg ? (longint'(1) << F) - longint'(d) : longint'(d);
        e.opnd = d;
        e.ab   = ab;
        if (m == 0) begin
            e.sat = 1'b1;
            e.val = MAXV;
        end else begin
            q     = ((longint'(1) << (2 * N)) + m / 2) / m;
            e.sat = (q > MAXV);
            if (e.sat) q = MAXV;
            e.val = (neg && !ab) ? -q : q;
        end
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t   e;
        longint got;
        if (rst_n && bus.o_valid && bus.i_ready) begin
            n_xfer++;
            got = longint'($signed(bus.o_data));
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1'b0, got, 0);
            end else begin
                e = exp_q.pop_front();
                if (e.sat)
                    check($sformatf("sat_result op=%h abs=%0d o_sat=%0d", e.opnd, e.ab, bus.o_sat),
                          bus.o_sat && (got == e.val), got, e.val);
                else
                    check($sformatf("result op=%h abs=%0d o_sat=%0d", e.opnd, e.ab, bus.o_sat),
                          !bus.o_sat && (got - e.val <= 2) && (e.val - got <= 2), got, e.val);
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            bus.i_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [F-1:0] d, input bit ab);
        int guard = 0;
        while (!bus.o_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!bus.o_ready) begin
            check("accept_timeout", 1'b0, 0, 1);
        end else begin
            bus.i_valid = 1'b1;
            bus.i_data  = d;
            bus.i_abs   = ab;
            exp_q.push_back(model(d, ab));
            @(posedge clk); #1;
            bus.i_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || !bus.o_ready) && guard < 400) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain", exp_q.size() == 0 && bus.o_ready, exp_q.size(), 0);
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!bus.o_valid && cycles < 60) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int     lat;
        int     x0;
        exp_t   held;
        longint got;
        logic [F-1:0] d;

        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_abs   = 1'b0;
        bus.i_ready = 1'b1;

        #12;
        check("reset_o_ready", bus.o_ready == 1'b1, bus.o_ready, 1);
        check("reset_o_valid", bus.o_valid == 1'b0, bus.o_valid, 0);
        check("reset_o_data", bus.o_data == '0, bus.o_data, 0);
        check("reset_o_sat", bus.o_sat == 1'b0, bus.o_sat, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // 2.0 with latency measurement from the accept edge.
        send(24'h002000, 1'b0);
        wait_valid(lat);
        check("latency", lat == 3 + 2 * ITERS, lat, 3 + 2 * ITERS);
        drain();

        send(24'hFFC000, 1'b0);
        send(24'hFFC000, 1'b1);
        send(24'h000000, 1'b0);
        send(24'h000001, 1'b0);
        send(24'hFFFFFF, 1'b0);
        send(24'h800000, 1'b0);
        send(24'h800000, 1'b1);
        send(24'h000003, 1'b0);
        drain();
        send(24'h800000, 1'b0);
        drain();

        // Asynchronous reset while the FSM sits in SEED discards the operation.
        send(24'h003000, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("midreset_o_data", bus.o_data == '0, bus.o_data, 0);
        check("midreset_o_valid", bus.o_valid == 1'b0, bus.o_valid, 0);
        check("midreset_o_sat", bus.o_sat == 1'b0, bus.o_sat, 0);
        check("midreset_o_ready", bus.o_ready == 1'b1, bus.o_ready, 1);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        x0 = n_xfer;
        repeat (15) @(posedge clk);
        #1;
        check("midreset_no_result", n_xfer == x0 && bus.o_ready, n_xfer, x0);
        send(24'h004000, 1'b0);
        drain();

        // Backpressure: result held for 20 cycles while i_valid toggles.
        bus.i_ready = 1'b0;
        send(24'h001800, 1'b1);
        held = model(24'h001800, 1'b1);
        wait_valid(lat);
        check("bp_valid_seen", bus.o_valid == 1'b1, bus.o_valid, 1);
        for (int i = 0; i < 20; i++) begin
            bus.i_valid = i[0];
            bus.i_data  = F'($urandom);
            bus.i_abs   = 1'($urandom);
            @(posedge clk); #1;
            got = longint'($signed(bus.o_data));
            check($sformatf("bp_hold cycle=%0d o_ready=%0d o_valid=%0d", i, bus.o_ready, bus.o_valid),
                  !bus.o_ready && bus.o_valid && !bus.o_sat &&
                  (got - held.val <= 2) && (held.val - got <= 2), got, held.val);
        end
        bus.i_valid = 1'b0;
        x0 = n_xfer;
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_after_release", bus.o_ready && !bus.o_valid, bus.o_ready, 1);
        repeat (15) @(posedge clk);
        #1;
        check("bp_single_transfer", n_xfer == x0 + 1, n_xfer, x0 + 1);
        drain();

        // Random sweep with random result backpressure.
        rand_ready = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            case ($urandom_range(0, 3))
                0, 1:    d = F'($urandom);
                2:       d = F'($urandom_range(0, 255)) ^ ({F{1'($urandom)}});
                default: d = F'($urandom_range(0, 16)) << $urandom_range(0, F - 1);
            endcase
            send(d, 1'($urandom));
        end
        rand_ready = 1'b0;
        @(posedge clk); #2;
        bus.i_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
